// File: rtl/nbcac_5di_decoder_pipe.sv
// Two-stage receive-side decoder for the 5-bit NBCAC crosstalk-avoidance bus.
// It also keeps a saturating count of adjacent opposite-direction wire transitions.
module nbcac_5di_decoder_pipe #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:1]       d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       v_out,
  output logic             range_err,
  output logic [CNT_W-1:0] ft_cnt,
  input  logic             clr_cnt
);

  logic             s1_v;
  logic             s2_v;
  logic             adv1;
  logic             adv2;
  logic             accept;
  logic [5:0]       pa;
  logic [5:0]       pb;
  logic [5:0]       pa_next;
  logic [5:0]       pb_next;
  logic [5:0]       sum;
  logic [7:1]       prev_d;
  logic [7:1]       rise;
  logic [7:1]       fall;
  logic             ft_event;
  logic             cnt_sat;

  // Each stage advances when the stage after it is empty or draining this cycle.
  // The resulting out_ready -> in_ready path is combinational on purpose, so
  // there are no bubbles and the pipe sustains one word per clock.
  assign adv2      = !s2_v || out_ready;
  assign adv1      = !s1_v || adv2;
  assign in_ready  = adv1;
  assign accept    = in_valid && adv1;
  assign out_valid = s2_v;

  // Split the weighted sum across the two stages: d1,d2,d3 and d4..d7.
  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    pa_next = {5'b0, d_in[1]}
            + (d_in[2] ? 6'd16 : 6'd0)
            + (d_in[3] ? 6'd10 : 6'd0);
    pb_next = (d_in[4] ? 6'd6 : 6'd0)
            + (d_in[5] ? 6'd4 : 6'd0)
            + (d_in[6] ? 6'd2 : 6'd0)
            + (d_in[7] ? 6'd2 : 6'd0);
  end

  assign sum = pa + pb;

  // Wire i and wire i+1 moving in opposite directions is the crosstalk worst case.
  assign rise     = ~prev_d & d_in;
  assign fall     = prev_d & ~d_in;
  assign ft_event = |((rise[6:1] & fall[7:2]) | (fall[6:1] & rise[7:2]));
  assign cnt_sat  = (ft_cnt == {CNT_W{1'b1}});

  // Stage 1: capture partial sums on accept; empty out when advancing without a new word.
  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  // NOTE: datapath registers are reset too, so v_out reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      pa   <= 6'd0;
      pb   <= 6'd0;
    end else if (accept) begin
      s1_v <= 1'b1;
      pa   <= pa_next;
      pb   <= pb_next;
    end else if (adv1) begin
      s1_v <= 1'b0;
    end
  end

  // Stage 2: out-of-range words are still delivered, wrapped mod 32 and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v      <= 1'b0;
      v_out     <= 5'd0;
      range_err <= 1'b0;
    end else if (adv2) begin
      s2_v <= s1_v;
      if (s1_v) begin
        v_out     <= sum[4:0];
        range_err <= sum[5] || (sum > 6'd31);
      end
    end
  end

  // Transition monitor: history follows accepted words only; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_d <= 7'b0;
    end else if (accept) begin
      prev_d <= d_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ft_cnt <= '0;
    end else if (clr_cnt) begin
      ft_cnt <= '0;
    end else if (accept && ft_event && !cnt_sat) begin
      ft_cnt <= ft_cnt + 1'b1;
    end
  end

endmodule

// File: doc/nbcac_5di_decoder_pipe.md
Name: nbcac_5di_decoder_pipe

Overview:
Receive-side decoder for the 5-bit data-in (5di) NBCAC crosstalk-avoidance bus. It converts a 7-wire codeword d[7:1] back to the 5-bit value v using the NBCAC weights (d1..d7 = 1,16,10,6,4,2,2). It is a 2-stage pipeline with valid/ready handshakes on both sides. It also monitors codeword range and opposite-direction transitions on adjacent wires between successive accepted codewords, for link diagnostics.

Parameters:
CNT_W, 8, width of the saturating forbidden-transition event counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  codeword on d_in is valid
in_ready  output  1  decoder can accept d_in this cycle
d_in  input  7 [7:1]  received NBCAC codeword, d_in[1] is the weight-1 wire
out_valid  output  1  v_out / range_err valid
out_ready  input  1  downstream accepts output this cycle
v_out  output  5 [4:0]  decoded value
range_err  output  1  weighted sum of the codeword exceeded 31; qualified by out_valid
ft_cnt  output  CNT_W  saturating count of accepted codewords with an adjacent opposite transition
clr_cnt  input  1  synchronous clear of ft_cnt

Behaviour:
- Reset (rst_n low, asynchronous): stage valids s1_v and s2_v = 0; out_valid = 0; v_out = 0; range_err = 0; ft_cnt = 0; previous-codeword register prev_d = 7'b0. All other datapath registers are cleared to 0.
- Flow control:
  - adv2 = !s2_v || out_ready; adv1 = !s1_v || adv2; in_ready = adv1.
  - This gives a combinational out_ready->in_ready path; no bubbles; full throughput of 1 word/clk.
- Input accept (in_valid && in_ready): stage 1 captures two partial sums, 6 bits each, zero-extended:
  - pa = d1 + 16*d2 + 10*d3, range 0..27
  - pb = 6*d4 + 4*d5 + 2*d6 + 2*d7, range 0..14
  - s1_v <= 1.
  - If adv1 is high and there is no accept, s1_v <= 0.
- Stage 2 (on adv2):
  - sum = pa + pb, 6 bits, max 41.
  - v_out <= sum[4:0]; range_err <= sum[5] || (sum > 31); s2_v <= s1_v.
  - When adv2 is high with s1_v = 0, s2_v <= 0 and v_out/range_err hold their values.
- out_valid = s2_v. Latency is 2 clocks from accept to out_valid when not stalled.
- While out_valid && !out_ready, v_out and range_err stay stable and both stages hold.
- Out-of-range codewords are still delivered: v_out = sum mod 32 with range_err = 1. The pipeline never drops a word.
- Forbidden-transition monitor, evaluated on every input accept:
  - rise[i] = !prev_d[i] && d_in[i]; fall[i] = prev_d[i] && !d_in[i].
  - An event occurs when, for any i in 1..6, (rise[i] && fall[i+1]) || (fall[i] && rise[i+1]).
  - At most 1 increment per accepted word. ft_cnt saturates at 2^CNT_W-1.
  - prev_d <= d_in on every accept.
- clr_cnt: ft_cnt <= 0 next clock and takes priority over a same-cycle increment. prev_d is not affected.
- Reset mid-operation: in-flight words are discarded, out_valid drops immediately (asynchronously), and the first word after reset is compared against 7'b0.
- Consistency: for every v in 0..31 produced by the 5di encoder, v_out == v and range_err == 0.

Test Plan:
- Reset then single word, out_ready=1: d_in=7'b0111001 -> two clocks later out_valid=1, v_out=13, range_err=0, ft_cnt=0.
- Back-to-back 7'b0000000, 7'b1100111 (v=31), with out_ready held 1 -> v_out = 0 then 31 on consecutive cycles. The 0->0x67 step has only rises, so ft_cnt stays 0.
- 7'b0111001 followed by 7'b1100111 -> d3 rises while d4 falls, so ft_cnt = 1. Feed the same pair 255 more times with CNT_W=8 -> ft_cnt saturates at 255; pulse clr_cnt -> 0.
- d_in=7'b1111111 -> v_out=9, range_err=1, out_valid=1. The word is delivered, not dropped.
- Backpressure: out_ready=0 for 5 cycles with 3 words offered -> exactly 2 words accepted, then in_ready=0. v_out is stable throughout; on out_ready=1, words emerge in order with no loss or duplication.
- Exhaustive: drive the encoder output for all v=0..31 in random order with random out_ready -> every v_out matches v, range_err=0; assert rst_n low mid-stream -> out_valid=0 immediately.
